fifo_rd_packer: RTL and testbench



---
 rtl/fifo_rd_packer.sv | 142 ++++++++++++++
 tb/tb_fifo_rd_packer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs async_fifo read words into wide beats behind a 2-entry skid buffer
module fifo_rd_packer #(
   parameter int    DSIZE       = 8,
   parameter int    RATIO       = 2,
   parameter string FALLTHROUGH = "TRUE",
   parameter int    CW          = $clog2(RATIO) + 1
) (
   input  logic                   rclk,
   input  logic                   rrst_n,
   input  logic                   fifo_empty,
   input  logic [DSIZE-1:0]       fifo_rdata,
   output logic                   fifo_ren,
   input  logic                   flush,
   output logic                   flush_done,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DSIZE*RATIO-1:0] m_data,
   output logic [CW-1:0]          m_count,
   output logic [15:0]            beat_cnt
);
   localparam int            IW   = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int            BW   = DSIZE * RATIO;
   localparam bit            SYNC = (FALLTHROUGH != "TRUE");
   localparam logic [IW-1:0] LAST = IW'(RATIO - 1);
   localparam logic [CW-1:0] FULL = CW'(RATIO);

   typedef enum logic [1:0] {RUN, WAIT, EMIT, DONE} state_t;
   state_t state, state_nx;

   logic [IW-1:0] req_idx, fill_idx;
   logic          rd_pend, inflight_beat;
   logic [BW-1:0] pack, pack_nx;
   logic [1:0]    obuf_cnt;
   logic [BW-1:0] ob_data [2];
   logic [CW-1:0] ob_count [2];
   logic          cap, cap_last, emit, push, pop, wr_slot;
   logic [BW-1:0] push_data;
   logic [CW-1:0] push_count;

   // Read issue: the beat-completing request waits until the skid buffer can take that beat
   always_comb begin
      fifo_ren = 1'b0;
      if (rrst_n && !fifo_empty && state == RUN) begin
         if (req_idx != LAST || ({1'b0, obuf_cnt} + {2'b00, inflight_beat}) < 3'd2)
            fifo_ren = 1'b1;
      end
   end

   // In FWFT mode data is valid with ren; in sync mode it arrives one cycle after ren
   assign cap      = SYNC ? rd_pend : fifo_ren;
   assign cap_last = cap && (fill_idx == LAST);

   // Pack register with the incoming word merged into its slot
   always_comb begin
      pack_nx = pack;
      pack_nx[int'(fill_idx) * DSIZE +: DSIZE] = fifo_rdata;
   end

   assign emit       = (state == EMIT) && (obuf_cnt < 2'd2);
   assign push       = cap_last || emit;
   assign push_data  = emit ? pack : pack_nx;
   assign push_count = emit ? CW'(fill_idx) : FULL;
   assign pop        = m_valid && m_ready;
   // Slot 1 takes the push only when an older entry remains after this cycle's pop
   assign wr_slot    = (obuf_cnt - {1'b0, pop}) != 2'd0;

   // Flush FSM next state: drain in-flight read, emit partial beat if any, then pulse done
   always_comb begin
      state_nx = state;
      case (state)
         RUN:     if (flush) state_nx = WAIT;
         WAIT:    if (!rd_pend) state_nx = (fill_idx == '0) ? DONE : EMIT;
         EMIT:    if (emit) state_nx = DONE;
         DONE:    state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   assign flush_done = (state == DONE);

   // FSM state register
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) state <= RUN;
      else         state <= state_nx;
   end

   // Request/fill indices, pack register and sync-mode in-flight tracking
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         req_idx       <= '0;
         fill_idx      <= '0;
         pack          <= '0;
         rd_pend       <= 1'b0;
         inflight_beat <= 1'b0;
      end else begin
         rd_pend       <= SYNC && fifo_ren;
         inflight_beat <= SYNC && fifo_ren && (req_idx == LAST);
         if (fifo_ren) req_idx <= (req_idx == LAST) ? '0 : req_idx + 1'b1;
         if (cap) begin
            if (cap_last) begin
               fill_idx <= '0;
               pack     <= '0;
            end else begin
               fill_idx <= fill_idx + 1'b1;
               pack     <= pack_nx;
            end
         end
         if (emit) begin
            fill_idx <= '0;
            req_idx  <= '0;
            pack     <= '0;
         end
      end
   end

   // Two-entry skid buffer, entry 0 is the head; accepted-beat counter
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         obuf_cnt    <= 2'd0;
         ob_data[0]  <= '0;
         ob_data[1]  <= '0;
         ob_count[0] <= '0;
         ob_count[1] <= '0;
         beat_cnt    <= 16'd0;
      end else begin
         obuf_cnt <= obuf_cnt + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            ob_data[0]  <= ob_data[1];
            ob_count[0] <= ob_count[1];
            beat_cnt    <= beat_cnt + 16'd1;
         end
         if (push) begin
            ob_data[wr_slot]  <= push_data;
            ob_count[wr_slot] <= push_count;
         end
      end
   end

   assign m_valid = (obuf_cnt != 2'd0);
   assign m_data  = ob_data[0];
   assign m_count = ob_count[0];
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed and randomized checks of fifo_rd_packer in FWFT and sync modes
`timescale 1ns/1ps
module tb_fifo_rd_packer;
   localparam int RATIO = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rrst_n;
   logic        empty_w [2];
   logic [7:0]  rdata_w [2];
   logic        ren_w   [2];
   logic        flush_w [2];
   logic        done_w  [2];
   logic        valid_w [2];
   logic        ready_w [2];
   logic [15:0] data_w  [2];
   logic [1:0]  count_w [2];
   logic [15:0] bcnt_w  [2];

   // Behavioural FIFOs: instance 0 first-word-fall-through, instance 1 registered read
   logic [7:0] mem [2][256];
   logic [7:0] wp [2];
   logic [7:0] rp [2] = '{default: 8'd0};
   logic       uf [2] = '{default: 1'b0};
   logic [7:0] sreg = 8'd0;

   assign empty_w[0] = (wp[0] == rp[0]);
   assign empty_w[1] = (wp[1] == rp[1]);
   assign rdata_w[0] = mem[0][rp[0]];
   assign rdata_w[1] = sreg;

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (ren_w[m]) begin
            if (wp[m] == rp[m]) uf[m] <= 1'b1;
            else                rp[m] <= rp[m] + 8'd1;
         end
      end
      if (ren_w[1] && wp[1] != rp[1]) sreg <= mem[1][rp[1]];
   end

   fifo_rd_packer #(.DSIZE(8), .RATIO(RATIO), .FALLTHROUGH("TRUE"))
   u_fw (.rclk(clk), .rrst_n(rrst_n), .fifo_empty(empty_w[0]), .fifo_rdata(rdata_w[0]),
         .fifo_ren(ren_w[0]), .flush(flush_w[0]), .flush_done(done_w[0]), .m_valid(valid_w[0]),
         .m_ready(ready_w[0]), .m_data(data_w[0]), .m_count(count_w[0]), .beat_cnt(bcnt_w[0]));

   fifo_rd_packer #(.DSIZE(8), .RATIO(RATIO), .FALLTHROUGH("FALSE"))
   u_sy (.rclk(clk), .rrst_n(rrst_n), .fifo_empty(empty_w[1]), .fifo_rdata(rdata_w[1]),
         .fifo_ren(ren_w[1]), .flush(flush_w[1]), .flush_done(done_w[1]), .m_valid(valid_w[1]),
         .m_ready(ready_w[1]), .m_data(data_w[1]), .m_count(count_w[1]), .beat_cnt(bcnt_w[1]));

   // Reference model: words group into beats in read order, a flush emits the remainder
   logic [15:0] exp_d [$];
   logic [1:0]  exp_c [$];
   logic [7:0]  pend  [$];
   int gen, cur, checks, errs, pulses;
   logic [7:0] start;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errs++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
      end
   endtask

   function automatic logic [15:0] pack_words();
      logic [15:0] v = '0;
      foreach (pend[k]) v = v | (16'(pend[k]) << (8 * k));
      return v;
   endfunction

   task automatic push_word(input logic [7:0] b);
      mem[cur][wp[cur]] = b;
      wp[cur] = wp[cur] + 8'd1;
      pend.push_back(b);
      if (pend.size() == RATIO) begin
         exp_d.push_back(pack_words());
         exp_c.push_back(2'(RATIO));
         pend.delete();
         gen++;
      end
   endtask

   task automatic model_flush();
      if (pend.size() > 0) begin
         exp_d.push_back(pack_words());
         exp_c.push_back(2'(pend.size()));
         pend.delete();
         gen++;
      end
   endtask

   task automatic model_reset();
      exp_d.delete();
      exp_c.delete();
      pend.delete();
      gen = 0;
      for (logic [7:0] p = rp[cur]; p != wp[cur]; p++) pend.push_back(mem[cur][p]);
   endtask

   // Scoreboard the handshake the coming edge will perform, then advance one cycle
   task automatic tick();
      if (rrst_n && valid_w[cur] && ready_w[cur]) begin
         chk("beat_expected", 32'(exp_d.size() != 0), 32'd1);
         if (exp_d.size() != 0) begin
            chk("beat_data", data_w[cur], exp_d[0]);
            chk("beat_count", count_w[cur], exp_c[0]);
            void'(exp_d.pop_front());
            void'(exp_c.pop_front());
         end
      end
      @(negedge clk);
      #1;
   endtask

   task automatic run_suite(input int md);
      cur = md;
      rrst_n = 1'b0;
      ready_w = '{default: 1'b0};
      flush_w = '{default: 1'b0};
      tick(); tick();
      chk("rst_ren", ren_w[cur], 0);
      chk("rst_valid", valid_w[cur], 0);
      chk("rst_data", data_w[cur], 0);
      chk("rst_count", count_w[cur], 0);
      chk("rst_bcnt", bcnt_w[cur], 0);
      chk("rst_done", done_w[cur], 0);
      rrst_n = 1'b1;
      model_reset();
      tick(); tick();

      // Basic packing and first-beat latency
      ready_w[cur] = 1'b1;
      push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
      repeat (1 + md) tick();
      chk("lat_early", valid_w[cur], 0);
      tick();
      chk("lat_first", valid_w[cur], 1);
      chk("first_data", data_w[cur], 16'h2211);
      repeat (8) tick();
      chk("basic_bcnt", bcnt_w[cur], gen);
      chk("basic_left", exp_d.size(), 0);

      // Backpressure: exactly five reads, head held stable
      ready_w[cur] = 1'b0;
      start = rp[cur];
      for (int i = 1; i <= 8; i++) push_word(8'(i * 8'h11));
      repeat (15) tick();
      chk("bp_reads", 8'(rp[cur] - start), 5);
      chk("bp_valid", valid_w[cur], 1);
      chk("bp_head", data_w[cur], 16'h2211);
      ready_w[cur] = 1'b1;
      repeat (15) tick();
      chk("bp_drain", 32'(rp[cur] == wp[cur]), 1);
      chk("bp_bcnt", bcnt_w[cur], gen);

      // Flush of a single word, then flush with nothing packed
      push_word(8'hAB);
      repeat (6) tick();
      chk("fl1_idle", valid_w[cur], 0);
      flush_w[cur] = 1'b1; model_flush(); tick(); flush_w[cur] = 1'b0;
      chk("fl1_a", done_w[cur], 0);
      tick(); chk("fl1_b", done_w[cur], 0);
      tick(); chk("fl1_done", done_w[cur], 1);
      chk("fl1_data", data_w[cur], 16'h00AB);
      chk("fl1_count", count_w[cur], 1);
      tick(); chk("fl1_clr", done_w[cur], 0);
      flush_w[cur] = 1'b1; tick(); flush_w[cur] = 1'b0;
      chk("fl0_a", done_w[cur], 0);
      tick(); chk("fl0_done", done_w[cur], 1);
      chk("fl0_novalid", valid_w[cur], 0);
      tick(); chk("fl0_clr", done_w[cur], 0);
      chk("fl0_bcnt", bcnt_w[cur], gen);

      // Flush while the skid buffer is full holds in EMIT until a pop
      ready_w[cur] = 1'b0;
      for (int i = 1; i <= 5; i++) push_word(8'(i * 8'h11));
      repeat (12) tick();
      chk("fl3_valid", valid_w[cur], 1);
      flush_w[cur] = 1'b1; model_flush(); tick(); flush_w[cur] = 1'b0;
      pulses = 0;
      repeat (8) begin pulses += int'(done_w[cur]); tick(); end
      chk("fl3_hold", pulses, 0);
      chk("fl3_bcnt_hold", bcnt_w[cur], gen - 3);
      ready_w[cur] = 1'b1;
      pulses = 0;
      repeat (10) begin tick(); pulses += int'(done_w[cur]); end
      chk("fl3_pulse", pulses, 1);
      chk("fl3_bcnt", bcnt_w[cur], gen);
      chk("fl3_left", exp_d.size(), 0);

      // Randomized traffic and backpressure, remainder flushed at the end
      for (int i = 0; i < 150; i++) begin
         ready_w[cur] = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) push_word(8'($urandom));
         tick();
      end
      ready_w[cur] = 1'b1;
      repeat (40) tick();
      flush_w[cur] = 1'b1; model_flush(); tick(); flush_w[cur] = 1'b0;
      repeat (8) tick();
      chk("rnd_left", exp_d.size(), 0);
      chk("rnd_bcnt", bcnt_w[cur], gen);
      chk("rnd_drain", 32'(rp[cur] == wp[cur]), 1);

      // Asynchronous reset mid-operation with a beat pending
      ready_w[cur] = 1'b0;
      push_word(8'h11); push_word(8'h22); push_word(8'h33);
      repeat (10) tick();
      chk("mr_valid_before", valid_w[cur], 1);
      push_word(8'h44);
      #1;
      chk("mr_ren_before", ren_w[cur], 1);
      rrst_n = 1'b0;
      #1;
      chk("mr_ren", ren_w[cur], 0);
      chk("mr_valid", valid_w[cur], 0);
      chk("mr_bcnt", bcnt_w[cur], 0);
      chk("mr_data", data_w[cur], 0);
      model_reset();
      tick(); tick();
      rrst_n = 1'b1;
      ready_w[cur] = 1'b1;
      push_word(8'h55);
      repeat (10) tick();
      chk("mr_post_bcnt", bcnt_w[cur], gen);
      chk("mr_post_left", exp_d.size(), 0);
   endtask

   initial begin
      checks = 0;
      errs = 0;
      gen = 0;
      cur = 0;
      wp = '{default: 8'd0};
      rrst_n = 1'b0;
      ready_w = '{default: 1'b0};
      flush_w = '{default: 1'b0};
      @(negedge clk);
      #1;
      for (int md = 0; md < 2; md++) run_suite(md);
      chk("no_underflow_fw", uf[0], 0);
      chk("no_underflow_sync", uf[1], 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
